// File: rtl/aes_pkg.sv
// Shared AES arithmetic: GF(2^8) helpers, affine maps, forward/inverse S-box, rcon table.
// Used by the key expander and by the cipher datapath tops.
package aes_pkg;

    localparam int         NR       = 10;
    localparam logic [3:0] LAST_RND = 4'd10;

    localparam logic [7:0] RCON [NR] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8); maps 0 to 0 naturally
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] s;
        r = 8'h01;
        s = x;
        for (int i = 1; i < 8; i++) begin
            s = gf_mul(s, s);
            r = gf_mul(r, s);
        end
        return r;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] b);
        return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return affine(gf_inv(x));
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return gf_inv(inv_affine(x));
    endfunction

endpackage

// File: rtl/aes_sbox_word.sv
// Four forward S-boxes applied bytewise across a 32-bit word (SubWord).
module aes_sbox_word
    import aes_pkg::*;
(
    input  logic [31:0] w_i,
    output logic [31:0] w_o
);

    always_comb begin
        w_o = {sbox(w_i[31:24]), sbox(w_i[23:16]), sbox(w_i[15:8]), sbox(w_i[7:0])};
    end

endmodule

// File: rtl/aes128_key_expand_invsbox.sv
// AES-128 key expander emitting one round key per clock after a key load,
// plus the combinational inverse S-box used by the inverse cipher datapath.
module aes128_key_expand_invsbox
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         kld,
    input  logic [127:0] key,
    output logic [31:0]  wo_0,
    output logic [31:0]  wo_1,
    output logic [31:0]  wo_2,
    output logic [31:0]  wo_3,
    input  logic [7:0]   inv_a,
    output logic [7:0]   inv_d
);

    logic [31:0] w0_q, w1_q, w2_q, w3_q;
    logic [31:0] w0_d, w1_d, w2_d, w3_d;
    logic [3:0]  rnd_q, rnd_d;
    logic [31:0] sub_w;
    logic [31:0] rcon_w;
    logic [31:0] t;

    aes_sbox_word u_subword (
        .w_i ({w3_q[23:0], w3_q[31:24]}),
        .w_o (sub_w)
    );

    // Past round 10 the index saturates and rcon drops to zero
    always_comb begin
        rcon_w = 32'h0;
        if (rnd_q < LAST_RND) rcon_w = {RCON[rnd_q], 24'h0};
        t    = sub_w ^ rcon_w;
        w0_d = w0_q ^ t;
        w1_d = w1_q ^ w0_d;
        w2_d = w2_q ^ w1_d;
        w3_d = w3_q ^ w2_d;
        rnd_d = (rnd_q == LAST_RND) ? LAST_RND : rnd_q + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            w0_q  <= 32'h0;
            w1_q  <= 32'h0;
            w2_q  <= 32'h0;
            w3_q  <= 32'h0;
            rnd_q <= 4'd0;
        end else if (kld) begin
            {w0_q, w1_q, w2_q, w3_q} <= key;
            rnd_q <= 4'd0;
        end else begin
            w0_q  <= w0_d;
            w1_q  <= w1_d;
            w2_q  <= w2_d;
            w3_q  <= w3_d;
            rnd_q <= rnd_d;
        end
    end

    assign wo_0  = w0_q;
    assign wo_1  = w1_q;
    assign wo_2  = w2_q;
    assign wo_3  = w3_q;
    assign inv_d = inv_sbox(inv_a);

endmodule

// File: tb/tb_aes128_key_expand_invsbox.sv
// Self-checking bench for the AES-128 key expander and inverse S-box.
module tb_aes128_key_expand_invsbox;

    logic         clk;
    logic         rst;
    logic         kld;
    logic [127:0] key;
    logic [31:0]  wo_0, wo_1, wo_2, wo_3;
    logic [7:0]   inv_a;
    logic [7:0]   inv_d;

    aes128_key_expand_invsbox dut (
        .clk   (clk),
        .rst   (rst),
        .kld   (kld),
        .key   (key),
        .wo_0  (wo_0),
        .wo_1  (wo_1),
        .wo_2  (wo_2),
        .wo_3  (wo_3),
        .inv_a (inv_a),
        .inv_d (inv_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [7:0] sb  [256];
    logic [7:0] isb [256];

    typedef struct {
        logic [127:0] k;
        int           rounds;
        logic [127:0] exp;
    } kvec_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
    } ivec_t;

    kvec_t kv [4];
    ivec_t iv [7];

    function automatic logic [7:0] tb_xt(input logic [7:0] a);
        return a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
    endfunction

    function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ aa;
            aa = tb_xt(aa);
        end
        return acc;
    endfunction

    // Independent S-box: inverse by exhaustive search, affine by the bit formula
    task automatic build_tables();
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] c;
        int         bi;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0)
                for (int y = 1; y < 256; y++)
                    if (tb_gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++) begin
                bi = i;
                s[i] = inv[bi] ^ inv[(bi + 4) % 8] ^ inv[(bi + 5) % 8]
                     ^ inv[(bi + 6) % 8] ^ inv[(bi + 7) % 8] ^ c[bi];
            end
            sb[x]  = s;
            isb[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] model_rk(input logic [127:0] k, input int n);
        logic [31:0] w [0:59];
        logic [31:0] tmp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
        for (int i = 4; i < 4 * (n + 1); i++) begin
            tmp = w[i - 1];
            if (i % 4 == 0) begin
                tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]};
                if (i / 4 <= 10) begin
                    tmp = tmp ^ {rc, 24'h0};
                    rc  = tb_xt(rc);
                end
            end
            w[i] = w[i - 4] ^ tmp;
        end
        return {w[4 * n], w[4 * n + 1], w[4 * n + 2], w[4 * n + 3]};
    endfunction

    task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [127:0] k);
        kld = 1'b1;
        key = k;
        step();
        kld = 1'b0;
    endtask

    function automatic logic [127:0] rnd_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    logic [127:0] rk;
    assign rk = {wo_0, wo_1, wo_2, wo_3};

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] k;
        logic [127:0] k2;

        kv[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
        kv[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 1,  128'ha0fafe1788542cb123a339392a6c7605};
        kv[2] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        kv[3] = '{128'h000102030405060708090a0b0c0d0e0f, 10, 128'h13111d7fe3944a17f307a78b4d2b30c5};

        iv[0] = '{8'h00, 8'h52};
        iv[1] = '{8'h01, 8'h09};
        iv[2] = '{8'h63, 8'h00};
        iv[3] = '{8'h53, 8'h50};
        iv[4] = '{8'hff, 8'h7d};
        iv[5] = '{8'hed, 8'h53};
        iv[6] = '{8'h7c, 8'h01};

        build_tables();

        rst   = 1'b0;
        kld   = 1'b1;
        key   = rnd_key();
        inv_a = 8'h00;
        repeat (2) step();
        chk128("reset_zero", rk, 128'h0);

        // After reset the all-zero state expands deterministically
        rst = 1'b1;
        kld = 1'b0;
        for (int r = 1; r <= 3; r++) begin
            step();
            chk8("reset_no_x", {7'h0, $isunknown(rk)}, 8'h00);
            chk128("post_reset_expand", rk, model_rk(128'h0, r));
        end

        foreach (kv[i]) begin
            load(kv[i].k);
            repeat (kv[i].rounds) step();
            chk128("fips_vector", rk, kv[i].exp);
        end

        // Random keys through all rounds and past saturation
        for (int n = 0; n < 5; n++) begin
            k = rnd_key();
            load(k);
            chk128("rand_round0", rk, k);
            for (int r = 1; r <= 12; r++) begin
                step();
                chk128("rand_round", rk, model_rk(k, r));
            end
        end

        // Reload in the middle of a sequence
        k  = 128'h000102030405060708090a0b0c0d0e0f;
        k2 = rnd_key();
        load(k);
        repeat (5) step();
        chk128("mid_round5", rk, model_rk(k, 5));
        load(k2);
        chk128("mid_reload_round0", rk, k2);
        for (int r = 1; r <= 10; r++) begin
            step();
            chk128("mid_restart", rk, model_rk(k2, r));
        end

        // kld held high: outputs follow the latest key
        kld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            k   = rnd_key();
            key = k;
            step();
            chk128("kld_held", rk, k);
        end
        kld = 1'b0;
        key = rnd_key();
        step();
        chk128("kld_drop_r1", rk, model_rk(k, 1));
        step();
        chk128("kld_drop_r2", rk, model_rk(k, 2));

        // Reset beats kld
        k = rnd_key();
        load(k);
        repeat (3) step();
        rst = 1'b0;
        kld = 1'b1;
        key = rnd_key();
        step();
        chk128("reset_priority", rk, 128'h0);
        rst = 1'b1;
        kld = 1'b0;

        foreach (iv[i]) begin
            inv_a = iv[i].a;
            #1;
            chk8("invs_spot", inv_d, iv[i].d);
        end

        for (int x = 0; x < 256; x++) begin
            chk8("pkg_sbox", aes_pkg::sbox(8'(x)), sb[x]);
            inv_a = aes_pkg::sbox(8'(x));
            #1;
            chk8("invs_of_s", inv_d, 8'(x));
            inv_a = 8'(x);
            #1;
            chk8("invs_table", inv_d, isb[x]);
            chk8("s_of_invs", aes_pkg::sbox(inv_d), 8'(x));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
